// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) arbiter in front of a single
// synchronous memory with registered read data.
//
// Ports:
//   clock, reset          - clock, asynchronous active-low reset
//   i_req/i_addr          - fetch request, held until i_ack
//   i_ack/i_rdata         - one-cycle fetch completion, read word
//   d_req/d_we/d_addr/
//   d_wdata               - data request (load/store), held until d_ack
//   d_ack/d_rdata         - one-cycle data completion, read word
//   mem_address/
//   mem_data_in/
//   mem_read_write        - memory command (registered), 1 = write
//   mem_data_out          - memory read data, valid the cycle after sampling
//
// Each access takes IDLE -> ACCESS -> RESP. In RESP the other port is granted
// directly if it is waiting, so back-to-back traffic alternates without IDLE.
module mem_arbiter #(
    parameter  int unsigned PRIORITY_MODE = 0,
    localparam int unsigned ADDR_W        = 32,
    localparam int unsigned DATA_W        = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_read_write,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    state_t   state_q, state_d;
    port_t    grant_q, grant_d;
    port_t    last_q, last_d;
    mem_cmd_t cmd_q, cmd_d;
    logic     rw_q, rw_d;
    logic     i_ack_q, i_ack_d;
    logic     d_ack_q, d_ack_d;

    // Winner selection when starting from IDLE
    logic  idle_valid_c;
    port_t idle_port_c;

    always_comb begin
        idle_valid_c = i_req | d_req;
        idle_port_c  = PORT_I;
        if (i_req && d_req) begin
            // Mode 0 alternates against the last grant; mode 1 always favours data
            if ((PRIORITY_MODE != 0) || (last_q == PORT_I)) begin
                idle_port_c = PORT_D;
            end else begin
                idle_port_c = PORT_I;
            end
        end else if (d_req) begin
            idle_port_c = PORT_D;
        end
    end

    // The port that did not win the current access, and whether it is waiting
    logic  other_req_c;
    port_t other_port_c;

    always_comb begin
        other_port_c = PORT_I;
        other_req_c  = i_req;
        if (grant_q == PORT_I) begin
            other_port_c = PORT_D;
            other_req_c  = d_req;
        end
    end

    // Next-state and registered-output logic
    logic  grant_en_c;
    port_t grant_port_c;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        cmd_d        = cmd_q;
        rw_d         = 1'b0;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        grant_en_c   = 1'b0;
        grant_port_c = PORT_I;

        unique case (state_q)
            ST_IDLE: begin
                if (idle_valid_c) begin
                    grant_en_c   = 1'b1;
                    grant_port_c = idle_port_c;
                end
            end
            ST_ACCESS: begin
                // Memory samples the command at this edge; read data lands in RESP
                state_d = ST_RESP;
                i_ack_d = (grant_q == PORT_I);
                d_ack_d = (grant_q == PORT_D);
            end
            ST_RESP: begin
                // The winner's own request is still up during its ack, so only
                // the other port is eligible for a direct hand-over
                if (other_req_c) begin
                    grant_en_c   = 1'b1;
                    grant_port_c = other_port_c;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant_en_c) begin
            state_d = ST_ACCESS;
            grant_d = grant_port_c;
            last_d  = grant_port_c;
            if (grant_port_c == PORT_D) begin
                cmd_d = '{addr: d_addr, wdata: d_wdata};
                rw_d  = d_we;
            end else begin
                cmd_d = '{addr: i_addr, wdata: '0};
            end
        end
    end

    // State and output registers; reset kills any in-flight store at once
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            grant_q <= PORT_D;
            last_q  <= PORT_D;
            cmd_q   <= '0;
            rw_q    <= 1'b0;
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cmd_q   <= cmd_d;
            rw_q    <= rw_d;
            i_ack_q <= i_ack_d;
            d_ack_q <= d_ack_d;
        end
    end

    assign mem_address    = cmd_q.addr;
    assign mem_data_in    = cmd_q.wdata;
    assign mem_read_write = rw_q;
    assign i_ack          = i_ack_q;
    assign d_ack          = d_ack_q;

    // Read data is steered straight from memory during the ack cycle
    assign i_rdata = i_ack_q ? mem_data_out : '0;
    assign d_rdata = d_ack_q ? mem_data_out : '0;

endmodule
